data_memory_responder: RTL and testbench

Data-memory slave for Pipelined_Processor. It answers the processor's MemRead/MemWrite/MemAddr/MemData bus and drives MemOutput.
- Replaces the constant MemOutput stub in the top-level benches.
- Adds a reset-time clear sweep, address-fault detection, saturating access counters and a debug read port for bench inspection.

---
 rtl/data_memory_responder_pkg.sv | 14 +
 rtl/data_memory_responder_mem_array_sp.sv | 42 ++++
 rtl/data_memory_responder.sv | 110 +++++++++++
 tb/tb_data_memory_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: default bus geometry
// and FSM state encoding, aligned with Pipelined_Processor.
package data_memory_responder_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ADDR_BITS   = 8;
  localparam int DEF_COUNT_WIDTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } memState_t;

endpackage

// File: rtl/data_memory_responder_mem_array_sp.sv
// Single-port word array: one write port, registered read port with
// write-first bypass, and a combinational debug read port.
module data_memory_responder_mem_array_sp
  import data_memory_responder_pkg::*;
#(
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int AddrBits  = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [AddrBits-1:0]  addr,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata,
  input  logic [AddrBits-1:0]  dbgAddr,
  output logic [DataWidth-1:0] dbgValue
);

  localparam int Depth = 1 << AddrBits;

  // The array itself has no reset; zeroing is done by the owner's sweep.
  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // A simultaneous read and write of the same word returns the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= we ? wdata : mem[addr];
    end
  end

  assign dbgValue = mem[dbgAddr];

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory slave for the pipelined processor: reset-time clear sweep,
// address-range fault flag, saturating access counters and a debug port.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DataWidth    = DEF_DATA_WIDTH,
  parameter int AddrBits     = DEF_ADDR_BITS,
  parameter bit ClearOnReset = 1'b1,
  parameter int CountWidth   = DEF_COUNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [DataWidth-1:0]  MemAddr,
  input  logic [DataWidth-1:0]  MemData,
  output logic [DataWidth-1:0]  MemOutput,
  output logic                  Busy,
  output logic                  AddrFault,
  input  logic [AddrBits-1:0]   dbg_addr,
  output logic [DataWidth-1:0]  dbg_value,
  output logic [CountWidth-1:0] read_count,
  output logic [CountWidth-1:0] write_count
);

  localparam logic [AddrBits-1:0]   LastAddr = '1;
  localparam logic [CountWidth-1:0] CountMax = '1;

  memState_t             state;
  logic [AddrBits-1:0]   clrPtr;
  logic                  addrHigh;
  logic                  inIdle;
  logic                  clearing;
  logic                  acceptRead;
  logic                  acceptWrite;
  logic                  faultNow;
  logic                  arrWe;
  logic [AddrBits-1:0]   arrAddr;
  logic [DataWidth-1:0]  arrData;

  generate
    if (AddrBits < DataWidth) begin : g_range
      assign addrHigh = |MemAddr[DataWidth-1:AddrBits];
    end else begin : g_full
      assign addrHigh = 1'b0;
    end
  endgenerate

  // Handshake: MemRead/MemWrite act as valid and are taken on the edge they
  // are seen; ~Busy is the ready. There is no back-pressure or retry, so a
  // request presented while Busy is simply dropped.
  assign inIdle      = (state == ST_IDLE) && !RST;
  assign clearing    = (state == ST_CLEAR) && !RST;
  assign acceptRead  = inIdle && !addrHigh && MemRead;
  assign acceptWrite = inIdle && !addrHigh && MemWrite;
  assign faultNow    = inIdle && addrHigh && (MemRead || MemWrite);

  assign arrWe   = clearing || acceptWrite;
  assign arrAddr = clearing ? clrPtr : MemAddr[AddrBits-1:0];
  assign arrData = clearing ? '0 : MemData;

  data_memory_responder_mem_array_sp #(
    .DataWidth(DataWidth),
    .AddrBits (AddrBits)
  ) u_array (
    .clk     (CLK),
    .rst     (RST),
    .we      (arrWe),
    .re      (acceptRead),
    .addr    (arrAddr),
    .wdata   (arrData),
    .rdata   (MemOutput),
    .dbgAddr (dbg_addr),
    .dbgValue(dbg_value)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ClearOnReset ? ST_CLEAR : ST_IDLE;
      Busy        <= ClearOnReset;
      clrPtr      <= '0;
      AddrFault   <= 1'b0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          AddrFault <= 1'b0;
          clrPtr    <= clrPtr + 1'b1;
          // The edge that zeroes the last word also releases the bus.
          if (clrPtr == LastAddr) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          Busy      <= 1'b0;
          AddrFault <= faultNow;
          if (acceptRead && (read_count != CountMax)) begin
            read_count <= read_count + 1'b1;
          end
          if (acceptWrite && (write_count != CountMax)) begin
            write_count <= write_count + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder with a 16-word array and 4-bit counters:
// clear sweep, access vectors, faults, mid-sweep reset and saturation.
module tb_data_memory_responder;

  localparam int DW = 16;
  localparam int AB = 4;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [DW-1:0] MemAddr = '0;
  logic [DW-1:0] MemData = '0;
  logic [DW-1:0] MemOutput;
  logic          Busy;
  logic          AddrFault;
  logic [AB-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_value;
  logic [CW-1:0] read_count;
  logic [CW-1:0] write_count;

  data_memory_responder #(
    .DataWidth   (DW),
    .AddrBits    (AB),
    .ClearOnReset(1'b1),
    .CountWidth  (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemAddr    (MemAddr),
    .MemData    (MemData),
    .MemOutput  (MemOutput),
    .Busy       (Busy),
    .AddrFault  (AddrFault),
    .dbg_addr   (dbg_addr),
    .dbg_value  (dbg_value),
    .read_count (read_count),
    .write_count(write_count)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl[16];
  int            exp_rd = 0;
  int            exp_wr = 0;
  logic [DW-1:0] last_out = '0;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp_out;
    logic          exp_fault;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // driver: one access cycle, model update, then scoreboard compare
  task automatic access(input logic rd, input logic wr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW-1:0] exp_out,
                        input logic exp_fault, input string name);
    logic [DW-1:0] got;
    MemRead  = rd;
    MemWrite = wr;
    MemAddr  = addr;
    MemData  = data;
    if (addr[DW-1:AB] == '0) begin
      if (wr) mdl[addr[AB-1:0]] = data;
      if (rd && exp_rd < 15) exp_rd++;
      if (wr && exp_wr < 15) exp_wr++;
    end
    exp_q.push_back(exp_out);
    tick();
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    got = exp_q.pop_front();
    last_out = got;
    chk({name, "_out"}, 32'(MemOutput), 32'(got));
    chk({name, "_fault"}, 32'(AddrFault), 32'(exp_fault));
    chk({name, "_rdcnt"}, 32'(read_count), 32'(exp_rd));
    chk({name, "_wrcnt"}, 32'(write_count), 32'(exp_wr));
  endtask

  task automatic count_busy(output int n, output bit fault_seen);
    n = 0;
    fault_seen = 1'b0;
    while (Busy && n < 100) begin
      // stimulus that must be ignored while the sweep runs
      if (n == 5) begin
        MemWrite = 1'b1;
        MemAddr  = 16'h0002;
        MemData  = 16'hBEEF;
      end else if (n == 8) begin
        MemRead = 1'b1;
        MemAddr = 16'h0020;
      end else if (n == 9) begin
        MemRead = 1'b1;
        MemAddr = 16'h0002;
      end
      tick();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      if (AddrFault) fault_seen = 1'b1;
      n++;
    end
  endtask

  initial begin
    int  n;
    bit  fs;
    logic [DW-1:0] d;
    logic [AB-1:0] a;

    vecs[0]  = '{1'b0, 1'b1, 16'h0005, 16'hFFEB, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'hFFEB, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 16'h0003, 16'h1234, 16'h1234, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h8003, 16'h5555, 16'h1234, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h1234, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h000F, 16'hA5A5, 16'h1234, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 16'h000F, 16'h0000, 16'hA5A5, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0};

    // reset and initial clear sweep
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_busy", 32'(Busy), 32'd1);
    chk("rst_out", 32'(MemOutput), 32'd0);
    chk("rst_fault", 32'(AddrFault), 32'd0);
    chk("rst_rdcnt", 32'(read_count), 32'd0);
    chk("rst_wrcnt", 32'(write_count), 32'd0);
    n = 0;
    while (Busy && n < 100) begin
      tick();
      n++;
    end
    chk("sweep_cycles", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = AB'(i);
      #0.5;
      chk("clear_dbg", 32'(dbg_value), 32'd0);
      mdl[i] = '0;
    end

    // table-driven access vectors
    for (int i = 0; i < 12; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
             vecs[i].exp_out, vecs[i].exp_fault, $sformatf("vec%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = AB'(i);
      #0.5;
      chk("vec_dbg", 32'(dbg_value), 32'(mdl[i]));
    end

    // reset mid-sweep: the second reset restarts a full-length sweep
    @(negedge CLK);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    dbg_addr = 4'd3;
    #0.5;
    chk("sweep_dbg_below_ptr3", 32'(dbg_value), 32'd0);
    dbg_addr = 4'd5;
    #0.5;
    chk("sweep_dbg_below_ptr5", 32'(dbg_value), 32'd0);
    dbg_addr = 4'd15;
    #0.5;
    chk("sweep_dbg_above_ptr", 32'(dbg_value), 32'hA5A5);
    @(negedge CLK);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rerst_busy", 32'(Busy), 32'd1);
    count_busy(n, fs);
    chk("resweep_cycles", 32'(n), 32'd16);
    chk("resweep_no_fault", 32'(fs), 32'd0);
    chk("resweep_out", 32'(MemOutput), 32'd0);
    chk("resweep_rdcnt", 32'(read_count), 32'd0);
    chk("resweep_wrcnt", 32'(write_count), 32'd0);
    dbg_addr = 4'd2;
    #0.5;
    chk("busy_store_dropped", 32'(dbg_value), 32'd0);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    exp_rd = 0;
    exp_wr = 0;
    last_out = '0;

    // saturation: 20 stores with 4-bit counters
    for (int i = 0; i < 20; i++) begin
      a = AB'(i % 16);
      d = DW'($urandom_range(0, 16'hFFFF));
      access(1'b0, 1'b1, {12'h000, a}, d, last_out, 1'b0, "sat_store");
      dbg_addr = a;
      #0.5;
      chk("sat_mem", 32'(dbg_value), 32'(d));
    end
    chk("sat_wrcnt_max", 32'(write_count), 32'hF);
    access(1'b1, 1'b0, 16'h0003, 16'h0000, mdl[3], 1'b0, "sat_load");
    access(1'b1, 1'b0, 16'h000A, 16'h0000, mdl[10], 1'b0, "sat_load2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
